// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// cpu_ctrl_pkg
// Shared opcodes, ALU selects, FSM states and IR field positions for the
// hardwired control unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH0 = 4'd1,
    S_FETCH1 = 4'd2,
    S_FETCH2 = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP     = 4'd0,
    CL_ALU_REG = 4'd1,
    CL_ALU_IMM = 4'd2,
    CL_LDI     = 4'd3,
    CL_LD      = 4'd4,
    CL_ST      = 4'd5,
    CL_BR      = 4'd6,
    CL_JR      = 4'd7,
    CL_MFHI    = 4'd8,
    CL_MFLO    = 4'd9,
    CL_HALT    = 4'd10,
    CL_ILLEGAL = 4'd11
  } iclass_t;

endpackage

`default_nettype wire

// File: rtl/opcode_decoder.sv
// ============================================================================
// opcode_decoder
// Maps the 5-bit opcode to an instruction class, ALU select and illegal flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module opcode_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [4:0]          opc_i,
  output iclass_t             class_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                illegal_o
);

  always_comb begin
    class_o   = CL_ILLEGAL;
    alu_op_o  = ALU_OP_W'(ALU_ADD);
    illegal_o = 1'b0;
    case (opc_i)
      OP_LD:   class_o = CL_LD;
      OP_LDI:  class_o = CL_LDI;
      OP_ST:   class_o = CL_ST;
      OP_ADD:  class_o = CL_ALU_REG;
      OP_SUB:  begin class_o = CL_ALU_REG; alu_op_o = ALU_OP_W'(ALU_SUB); end
      OP_AND:  begin class_o = CL_ALU_REG; alu_op_o = ALU_OP_W'(ALU_AND); end
      OP_OR:   begin class_o = CL_ALU_REG; alu_op_o = ALU_OP_W'(ALU_OR);  end
      OP_ADDI: class_o = CL_ALU_IMM;
      OP_ANDI: begin class_o = CL_ALU_IMM; alu_op_o = ALU_OP_W'(ALU_AND); end
      OP_ORI:  begin class_o = CL_ALU_IMM; alu_op_o = ALU_OP_W'(ALU_OR);  end
      OP_BR:   class_o = CL_BR;
      OP_JR:   class_o = CL_JR;
      OP_MFHI: class_o = CL_MFHI;
      OP_MFLO: class_o = CL_MFLO;
      OP_NOP:  class_o = CL_NOP;
      OP_HALT: class_o = CL_HALT;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer
// Moore control FSM: fetch T0-T2, decode, execute T3-T7, halt.
// Revision: 1.0
// ============================================================================
`default_nettype none

module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_W     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [IR_W-1:0]     ir,
  input  logic                con_ff,
  input  logic                stop,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                MDRout,
  output logic                Zlowout,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                Yin,
  output logic                Cout,
  output logic                HIout,
  output logic                LOout,
  output logic                CONin,
  output logic                ram_read,
  output logic                ram_write,
  output logic                MD_read,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                run,
  output logic                illegal_op
);

  state_t                state_q, state_d;
  iclass_t               cls;
  logic [ALU_OP_W-1:0]   dec_alu;
  logic                  dec_illegal;
  logic                  instr_end;
  logic                  unused_ir_bits;

  assign unused_ir_bits = ^ir[OPC_LSB-1:0];

  opcode_decoder #(.ALU_OP_W(ALU_OP_W)) u_dec (
    .opc_i     (ir[OPC_MSB:OPC_LSB]),
    .class_o   (cls),
    .alu_op_o  (dec_alu),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    instr_end = 1'b0;
    case (state_q)
      S_RESET:  state_d = S_FETCH0;
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: begin
        if (cls == CL_HALT)     state_d = S_HALT;
        else if (cls == CL_NOP) instr_end = 1'b1;
        else                    state_d = S_T3;
      end
      S_T3: begin
        if (cls inside {CL_JR, CL_MFHI, CL_MFLO, CL_ILLEGAL}) instr_end = 1'b1;
        else                                                  state_d = S_T4;
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (cls inside {CL_ALU_REG, CL_ALU_IMM, CL_LDI}) instr_end = 1'b1;
        else                                             state_d = S_T6;
      end
      S_T6: begin
        if (cls == CL_BR) instr_end = 1'b1;
        else              state_d = S_T7;
      end
      S_T7:    instr_end = 1'b1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    // stop is only honoured on the cycle that finishes an instruction
    if (instr_end) state_d = stop ? S_HALT : S_FETCH0;
  end

  always_ff @(posedge clock) begin
    if (clear) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  assign MD_read = 1'b0;

  always_comb begin
    {PCout, MARin, IncPC, Zin, PCin, MDRin, IRin, MDRout, Zlowout, Gra, Grb,
     Grc, Rin, Rout, BAout, Yin, Cout, HIout, LOout, CONin, ram_read,
     ram_write} = '0;
    alu_op     = ALU_OP_W'(ALU_ADD);
    illegal_op = 1'b0;
    run        = (state_q != S_RESET) && (state_q != S_HALT);
    case (state_q)
      S_FETCH0: {PCout, MARin, IncPC, Zin} = '1;
      S_FETCH1: {Zlowout, PCin, ram_read, MDRin} = '1;
      S_FETCH2: {MDRout, IRin} = '1;
      S_T3: begin
        case (cls)
          CL_ALU_REG, CL_ALU_IMM: {Grb, Rout, Yin} = '1;
          CL_LDI, CL_LD, CL_ST:   {Grb, BAout, Yin} = '1;
          CL_BR:                  {Gra, Rout, CONin} = '1;
          CL_JR:                  {Gra, Rout, PCin} = '1;
          CL_MFHI:                {HIout, Gra, Rin} = '1;
          CL_MFLO:                {LOout, Gra, Rin} = '1;
          CL_ILLEGAL:             illegal_op = dec_illegal;
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          CL_ALU_REG: begin {Grc, Rout, Zin} = '1; alu_op = dec_alu; end
          CL_ALU_IMM: begin {Cout, Zin} = '1;      alu_op = dec_alu; end
          CL_LDI, CL_LD, CL_ST: {Cout, Zin} = '1;
          CL_BR:                {PCout, Yin} = '1;
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          CL_ALU_REG, CL_ALU_IMM, CL_LDI: {Zlowout, Gra, Rin} = '1;
          CL_LD, CL_ST:                   {Zlowout, MARin} = '1;
          CL_BR:                          {Cout, Zin} = '1;
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          CL_LD: {ram_read, MDRin} = '1;
          CL_ST: {Gra, Rout, MDRin} = '1;
          CL_BR: {Zlowout, PCin} = {2{con_ff}};
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          CL_LD: {MDRout, Gra, Rin} = '1;
          CL_ST: ram_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// tb_control_sequencer
// Directed bench for the hardwired control sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_control_sequencer;

  logic        clock, clear, con_ff, stop;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, Zin, PCin, MDRin, IRin, MDRout, Zlowout, Gra, Grb;
  logic Grc, Rin, Rout, BAout, Yin, Cout, HIout, LOout, CONin;
  logic ram_read, ram_write, MD_read, run, illegal_op;
  logic [3:0] alu_op;

  int total = 0;
  int bad   = 0;

  logic [21:0] strb;
  assign strb = {PCout, MARin, IncPC, Zin, PCin, MDRin, IRin, MDRout, Zlowout,
                 Gra, Grb, Grc, Rin, Rout, BAout, Yin, Cout, HIout, LOout,
                 CONin, ram_read, ram_write};

  localparam logic [21:0] M_PCOUT = 22'h1 << 21, M_MARIN = 22'h1 << 20;
  localparam logic [21:0] M_INCPC = 22'h1 << 19, M_ZIN   = 22'h1 << 18;
  localparam logic [21:0] M_PCIN  = 22'h1 << 17, M_MDRIN = 22'h1 << 16;
  localparam logic [21:0] M_IRIN  = 22'h1 << 15, M_MDROUT = 22'h1 << 14;
  localparam logic [21:0] M_ZLOW  = 22'h1 << 13, M_GRA   = 22'h1 << 12;
  localparam logic [21:0] M_GRB   = 22'h1 << 11, M_GRC   = 22'h1 << 10;
  localparam logic [21:0] M_RIN   = 22'h1 << 9,  M_ROUT  = 22'h1 << 8;
  localparam logic [21:0] M_BAOUT = 22'h1 << 7,  M_YIN   = 22'h1 << 6;
  localparam logic [21:0] M_COUT  = 22'h1 << 5,  M_HIOUT = 22'h1 << 4;
  localparam logic [21:0] M_LOOUT = 22'h1 << 3,  M_CONIN = 22'h1 << 2;
  localparam logic [21:0] M_RAMRD = 22'h1 << 1,  M_RAMWR = 22'h1 << 0;
  localparam logic [21:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [21:0] F1 = M_ZLOW | M_PCIN | M_RAMRD | M_MDRIN;
  localparam logic [21:0] F2 = M_MDROUT | M_IRIN;
  localparam logic [21:0] BUS = M_PCOUT | M_MDROUT | M_ZLOW | M_ROUT | M_BAOUT |
                                M_COUT | M_HIOUT | M_LOOUT;

  logic [21:0] obs_s [16];
  logic [3:0]  obs_a [16];
  logic        obs_r [16];
  logic        obs_il[16];
  logic [21:0] exp_s [16];
  logic [3:0]  exp_a [16];
  logic        exp_il[16];

  control_sequencer #(.IR_W(32), .ALU_OP_W(4)) dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .MDRout(MDRout), .Zlowout(Zlowout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Yin(Yin), .Cout(Cout), .HIout(HIout), .LOout(LOout), .CONin(CONin),
    .ram_read(ram_read), .ram_write(ram_write), .MD_read(MD_read),
    .alu_op(alu_op), .run(run), .illegal_op(illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock advance; every cycle also gets the single-bus-driver property.
  task automatic step();
    @(posedge clock);
    #1;
    total++;
    if ($countones(strb & BUS) > 1 || MD_read !== 1'b0) begin
      bad++;
      $display("FAIL bus_exclusive t=%0t: strb=%h MD_read=%b, want <=1 driver, MD_read=0",
               $time, strb, MD_read);
    end
  endtask

  task automatic capture(input logic [31:0] instr, input int n);
    ir = instr;
    for (int i = 0; i < n; i++) begin
      obs_s[i] = strb; obs_a[i] = alu_op; obs_r[i] = run; obs_il[i] = illegal_op;
      step();
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) begin
      exp_s[i] = '0; exp_a[i] = 4'd0; exp_il[i] = 1'b0;
    end
    exp_s[0] = F0; exp_s[1] = F1; exp_s[2] = F2;
  endtask

  task automatic test_reset();
    clear = 1'b1; stop = 1'b0; con_ff = 1'b0; ir = 32'hD000_0000;
    step(); step();
    total++;
    if (strb !== '0 || run !== 1'b0 || alu_op !== 4'd0 || illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: strb=%h run=%b alu=%0d ill=%b, want 0/0/0/0",
               strb, run, alu_op, illegal_op);
    end
    clear = 1'b0;
    step();
    total++;
    if (strb !== F0 || run !== 1'b1) begin
      bad++;
      $display("FAIL reset_to_fetch0: strb=%h run=%b, want strb=%h run=1", strb, run, F0);
    end
  endtask

  task automatic test_ldi();
    clear_exp();
    exp_s[3] = M_GRB | M_BAOUT | M_YIN;
    exp_s[4] = M_COUT | M_ZIN;
    exp_s[5] = M_ZLOW | M_GRA | M_RIN;
    capture(32'h0A00_0054, 6);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (obs_s[i] !== exp_s[i] || obs_a[i] !== exp_a[i] || obs_r[i] !== 1'b1 || obs_il[i] !== exp_il[i]) begin
        bad++;
        $display("FAIL ldi cyc%0d: strb=%h alu=%0d run=%b ill=%b, want strb=%h alu=%0d run=1 ill=%b",
                 i, obs_s[i], obs_a[i], obs_r[i], obs_il[i], exp_s[i], exp_a[i], exp_il[i]);
      end
    end
    total++;
    if (strb !== F0 || run !== 1'b1) begin
      bad++;
      $display("FAIL ldi_next_fetch: strb=%h run=%b, want strb=%h run=1", strb, run, F0);
    end
  endtask

  task automatic test_alu();
    logic [31:0] instr [3] = '{32'h1A92_0000, 32'h2000_0000, 32'h7000_0000};
    logic [3:0]  op    [3] = '{4'd0, 4'd1, 4'd3};
    logic        reg_f [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      clear_exp();
      exp_s[3] = M_GRB | M_ROUT | M_YIN;
      exp_s[4] = reg_f[k] ? (M_GRC | M_ROUT | M_ZIN) : (M_COUT | M_ZIN);
      exp_a[4] = op[k];
      exp_s[5] = M_ZLOW | M_GRA | M_RIN;
      capture(instr[k], 6);
      for (int i = 0; i < 6; i++) begin
        total++;
        if (obs_s[i] !== exp_s[i] || obs_a[i] !== exp_a[i] || obs_r[i] !== 1'b1 || obs_il[i] !== exp_il[i]) begin
          bad++;
          $display("FAIL alu%0d cyc%0d: strb=%h alu=%0d run=%b ill=%b, want strb=%h alu=%0d run=1 ill=%b",
                   k, i, obs_s[i], obs_a[i], obs_r[i], obs_il[i], exp_s[i], exp_a[i], exp_il[i]);
        end
      end
      total++;
      if (strb !== F0 || run !== 1'b1) begin
        bad++;
        $display("FAIL alu%0d_next_fetch: strb=%h run=%b, want strb=%h run=1", k, strb, run, F0);
      end
    end
  endtask

  task automatic test_ld_st();
    for (int k = 0; k < 2; k++) begin
      clear_exp();
      exp_s[3] = M_GRB | M_BAOUT | M_YIN;
      exp_s[4] = M_COUT | M_ZIN;
      exp_s[5] = M_ZLOW | M_MARIN;
      exp_s[6] = (k == 0) ? (M_RAMRD | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
      exp_s[7] = (k == 0) ? (M_MDROUT | M_GRA | M_RIN) : M_RAMWR;
      capture((k == 0) ? 32'h0000_0000 : 32'h1000_0000, 8);
      for (int i = 0; i < 8; i++) begin
        total++;
        if (obs_s[i] !== exp_s[i] || obs_a[i] !== exp_a[i] || obs_r[i] !== 1'b1 || obs_il[i] !== exp_il[i]) begin
          bad++;
          $display("FAIL ldst%0d cyc%0d: strb=%h alu=%0d run=%b ill=%b, want strb=%h alu=%0d run=1 ill=%b",
                   k, i, obs_s[i], obs_a[i], obs_r[i], obs_il[i], exp_s[i], exp_a[i], exp_il[i]);
        end
      end
      total++;
      if (strb !== F0 || run !== 1'b1) begin
        bad++;
        $display("FAIL ldst%0d_next_fetch: strb=%h run=%b, want strb=%h run=1", k, strb, run, F0);
      end
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      con_ff = k[0];
      clear_exp();
      exp_s[3] = M_GRA | M_ROUT | M_CONIN;
      exp_s[4] = M_PCOUT | M_YIN;
      exp_s[5] = M_COUT | M_ZIN;
      exp_s[6] = (k == 1) ? (M_ZLOW | M_PCIN) : 22'h0;
      capture(32'h9800_0000, 7);
      for (int i = 0; i < 7; i++) begin
        total++;
        if (obs_s[i] !== exp_s[i] || obs_a[i] !== exp_a[i] || obs_r[i] !== 1'b1 || obs_il[i] !== exp_il[i]) begin
          bad++;
          $display("FAIL br_con%0d cyc%0d: strb=%h alu=%0d run=%b ill=%b, want strb=%h alu=%0d run=1 ill=%b",
                   k, i, obs_s[i], obs_a[i], obs_r[i], obs_il[i], exp_s[i], exp_a[i], exp_il[i]);
        end
      end
      total++;
      if (strb !== F0 || run !== 1'b1) begin
        bad++;
        $display("FAIL br_con%0d_next_fetch: strb=%h run=%b, want strb=%h run=1", k, strb, run, F0);
      end
    end
    con_ff = 1'b0;
  endtask

  task automatic test_short();
    logic [31:0] instr [5] = '{32'hA000_0000, 32'hC000_0000, 32'hC800_0000,
                               32'hD000_0000, 32'hF800_0000};
    logic [21:0] t3 [5] = '{M_GRA | M_ROUT | M_PCIN, M_HIOUT | M_GRA | M_RIN,
                            M_LOOUT | M_GRA | M_RIN, 22'h0, 22'h0};
    int len [5] = '{4, 4, 4, 3, 4};
    for (int k = 0; k < 5; k++) begin
      clear_exp();
      exp_s[3]  = t3[k];
      exp_il[3] = (k == 4);
      capture(instr[k], len[k]);
      for (int i = 0; i < len[k]; i++) begin
        total++;
        if (obs_s[i] !== exp_s[i] || obs_a[i] !== exp_a[i] || obs_r[i] !== 1'b1 || obs_il[i] !== exp_il[i]) begin
          bad++;
          $display("FAIL short%0d cyc%0d: strb=%h alu=%0d run=%b ill=%b, want strb=%h alu=%0d run=1 ill=%b",
                   k, i, obs_s[i], obs_a[i], obs_r[i], obs_il[i], exp_s[i], exp_a[i], exp_il[i]);
        end
      end
      total++;
      if (strb !== F0 || run !== 1'b1 || illegal_op !== 1'b0) begin
        bad++;
        $display("FAIL short%0d_next_fetch: strb=%h run=%b ill=%b, want strb=%h run=1 ill=0",
                 k, strb, run, illegal_op, F0);
      end
    end
  endtask

  task automatic test_clear_mid();
    capture(32'h0000_0000, 4);
    clear = 1'b1;
    step();
    total++;
    if (strb !== '0 || run !== 1'b0) begin
      bad++;
      $display("FAIL clear_mid: strb=%h run=%b, want strb=0 run=0", strb, run);
    end
    clear = 1'b0;
    step();
    total++;
    if (strb !== F0 || run !== 1'b1) begin
      bad++;
      $display("FAIL clear_mid_refetch: strb=%h run=%b, want strb=%h run=1", strb, run, F0);
    end
  endtask

  task automatic test_stop();
    capture(32'h1A92_0000, 5);
    stop = 1'b1;
    capture(32'h1A92_0000, 1);
    total++;
    if (obs_s[0] !== (M_ZLOW | M_GRA | M_RIN)) begin
      bad++;
      $display("FAIL stop_t5: strb=%h, want %h", obs_s[0], M_ZLOW | M_GRA | M_RIN);
    end
    stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (strb !== '0 || run !== 1'b0) begin
        bad++;
        $display("FAIL stop_halt cyc%0d: strb=%h run=%b, want strb=0 run=0", i, strb, run);
      end
      step();
    end
    clear = 1'b1; step(); clear = 1'b0; step();
    total++;
    if (strb !== F0 || run !== 1'b1) begin
      bad++;
      $display("FAIL stop_recover: strb=%h run=%b, want strb=%h run=1", strb, run, F0);
    end
  endtask

  task automatic test_halt();
    int halt_bad = 0;
    clear_exp();
    capture(32'hD800_0000, 3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_s[i] !== exp_s[i] || obs_r[i] !== 1'b1) begin
        bad++;
        $display("FAIL halt_fetch cyc%0d: strb=%h run=%b, want strb=%h run=1",
                 i, obs_s[i], obs_r[i], exp_s[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      total++;
      if (strb !== '0 || run !== 1'b0 || illegal_op !== 1'b0) begin
        bad++; halt_bad++;
        if (halt_bad < 4)
          $display("FAIL halt_hold cyc%0d: strb=%h run=%b ill=%b, want 0/0/0", i, strb, run, illegal_op);
      end
      step();
    end
    clear = 1'b1;
    step();
    total++;
    if (strb !== '0 || run !== 1'b0) begin
      bad++;
      $display("FAIL halt_clear: strb=%h run=%b, want strb=0 run=0", strb, run);
    end
    clear = 1'b0;
    step();
    total++;
    if (strb !== F0 || run !== 1'b1) begin
      bad++;
      $display("FAIL halt_refetch: strb=%h run=%b, want strb=%h run=1", strb, run, F0);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_alu();
    test_ld_st();
    test_branch();
    test_short();
    test_clear_mid();
    test_stop();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit that drives the control inputs of the DataPath.
- Sequences instruction fetch (T0–T2), then decodes IR[31:27] and runs the execute steps (T3–T7) for a subset of the ISA.
- Replaces the hand-written FSM stimulus currently used in DataPath benches; its outputs connect one-to-one to the same-named DataPath inputs.

Parameters:
- IR_W, 32, instruction register width
- ALU_OP_W, 4, width of alu_op select

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  reset; one clock, reset is synchronous and active-high
- ir  in  IR_W  current IR contents from DataPath
- con_ff  in  1  branch condition flip-flop output
- stop  in  1  halt request, sampled at instruction end
- PCout, MARin, IncPC, Zin, PCin, MDRin, IRin, MDRout, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Yin, Cout, HIout, LOout, CONin  out  1 each  DataPath strobes
- ram_read, ram_write  out  1  memory strobes
- MD_read  out  1  MDR source select; held 0 here (bus source), 1 only in test preload
- alu_op  out  ALU_OP_W  ALU function select
- run  out  1  high while executing, low in HALT
- illegal_op  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Outputs are pure functions of state, plus ir/con_ff where noted. Registered state only; no output registers.
- Reset:
  - clear=1 at a rising edge → state RESET.
  - In RESET all outputs are 0, alu_op=ADD (0), run=0.
  - RESET → FETCH0 on the next edge with clear=0.
  - clear overrides every state, including mid-instruction and HALT.
- Fetch states (run=1 from FETCH0 onward):
  - FETCH0: PCout MARin IncPC Zin.
  - FETCH1: Zlowout PCin ram_read MDRin.
  - FETCH2: MDRout IRin.
  - FETCH2 → DECODE state T3 of the class selected by ir[31:27]; IR is valid from T3.
- Opcodes (ir[31:27]): ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, br 10011, jr 10100, mfhi 11000, mflo 11001, nop 11010, halt 11011.
- Execute sequences:
  - ALU-reg: T3 Grb Rout Yin; T4 Grc Rout Zin alu_op=op; T5 Zlowout Gra Rin.
  - ALU-imm: T3 Grb Rout Yin; T4 Cout Zin alu_op=op; T5 Zlowout Gra Rin.
  - ldi: T3 Grb BAout Yin; T4 Cout Zin ADD; T5 Zlowout Gra Rin.
  - ld: same as ldi through T4; T5 Zlowout MARin; T6 ram_read MDRin; T7 MDRout Gra Rin.
  - st: same as ldi through T4; T5 Zlowout MARin; T6 Gra Rout MDRin; T7 ram_write.
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin ADD; T6 Zlowout PCin only if con_ff=1, otherwise no strobes.
  - jr: T3 Gra Rout PCin.
  - mfhi / mflo: T3 HIout (or LOout) Gra Rin.
  - nop: no execute states.
  - halt: → HALT.
  - Undefined opcode: illegal_op=1 during the single DECODE cycle, no strobes, then treated as nop.
- Instruction end (last execute state, or FETCH2 for nop):
  - Next state is HALT if stop=1, else FETCH0.
- HALT: all strobes 0, run=0; stays until clear.
- Total cycles per instruction from FETCH0: nop 3, jr/mfhi/mflo 4, ALU/ldi 6, br 7, ld/st 8.
- alu_op is ADD in every state not listed above.
- At most one bus driver is asserted in any state; the bench checks this.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams
  - alu_op encodings: ADD 0, SUB 1, AND 2, OR 3
  - state enumeration
  - instruction field slices: OPC [31:27], RA [26:23], RB [22:19], RC [18:15]
- One sub-module, opcode_decoder: combinational, maps ir[31:27] to an instruction class, an alu_op, and an illegal flag.
- The sequencer FSM lives in control_sequencer.

Test Plan:
- Release clear after 2 cycles → exactly 1 RESET cycle, then FETCH0 with PCout=MARin=IncPC=Zin=1 and run=1.
- ir=0x0A000054 (ldi R4,#0x54) → T3 BAout/Grb/Yin, T4 Cout/Zin with alu_op=0, T5 Zlowout/Gra/Rin; FETCH0 six cycles after the first FETCH0.
- ir=0x1A920000 (add R5,R2,R4) → T4 Grc/Rout/Zin with alu_op=0; ld (ir=0x00000000) → ram_read at T6, MDRout/Gra/Rin at T7, 8-cycle instruction.
- br with con_ff=0 → T6 asserts no PCin; repeat with con_ff=1 → T6 asserts Zlowout and PCin.
- ir=0xD8000000 (halt) → run=0 and all strobes 0 for 20 cycles; clear=1 → RESET, then FETCH0.
- ir=0xF8000000 (undefined) → illegal_op high exactly 1 cycle; stop=1 during T5 of an add → next state HALT, not FETCH0.
